whackamole_game_ctrl: RTL and testbench

Game-state controller for the whack-a-mole design: owns mole placement, hit judging, score keeping and the game timer. It is the producer side of the display interface and drives `vga_display` directly through `mole_position`, `guess_correct`, `guess_wrong`, `game_over`, `digit_1` and `digit_2`. It replaces the constant tie-offs used in the board-level display bench and runs on the same system clock as `vga_display`.

---
 rtl/whackamole_game_ctrl_if.sv | 26 ++
 rtl/whackamole_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_whackamole_game_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/whackamole_game_ctrl_if.sv
// Game-state bus between the whack-a-mole controller and its environment.
// The master side is the controller: it consumes tick/start/hit and
// produces the display-facing signals that feed vga_display.
interface whackamole_game_ctrl_if;
  logic       tick;
  logic       start;
  logic [7:0] hit;
  logic [2:0] mole_position;
  logic       guess_correct;
  logic       guess_wrong;
  logic       game_over;
  logic [3:0] digit_1;
  logic [3:0] digit_2;

  modport master (
    input  tick, start, hit,
    output mole_position, guess_correct, guess_wrong, game_over,
           digit_1, digit_2
  );

  modport slave (
    output tick, start, hit,
    input  mole_position, guess_correct, guess_wrong, game_over,
           digit_1, digit_2
  );
endinterface

// File: rtl/whackamole_game_ctrl.sv
// Whack-a-mole game-state controller: mole placement from an 8-bit LFSR,
// hit judging with lockout, saturating BCD score and tick-driven timers.
// Every output comes straight from a flop.
module whackamole_game_ctrl #(
  parameter int         GAME_TICKS = 60,
  parameter int         MOLE_TICKS = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  whackamole_game_ctrl_if.master        bus
);

  localparam int GW = $clog2(GAME_TICKS + 1);
  localparam int MW = $clog2(MOLE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [2:0]    mole_q, mole_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;
  logic          game_over_q, game_over_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [GW-1:0] game_timer_q, game_timer_d;
  logic [MW-1:0] mole_timer_q, mole_timer_d;

  logic          lfsr_fb;
  logic [2:0]    placed_pos;
  logic          hit_valid;
  logic          hit_good;

  // Fibonacci LFSR, taps 8,6,5,4; placement always moves the mole.
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign placed_pos = (lfsr_q[2:0] == mole_q) ? mole_q + 3'd1 : lfsr_q[2:0];

  // A hit is only judged while neither flag is showing; a good hit is exactly
  // the one-hot bit of the current mole.
  assign hit_valid = (bus.hit != 8'd0) && !correct_q && !wrong_q;
  assign hit_good  = hit_valid && (bus.hit == (8'd1 << mole_q));

  // Next-state and datapath: start wins, then hit judging, then tick handling.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    lfsr_d       = {lfsr_q[6:0], lfsr_fb};
    mole_d       = mole_q;
    correct_d    = correct_q;
    wrong_d      = wrong_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    game_timer_d = game_timer_q;
    mole_timer_d = mole_timer_q;

    if (bus.start) begin
      state_d      = ST_PLAY;
      tens_d       = 4'd0;
      ones_d       = 4'd0;
      game_timer_d = GW'(GAME_TICKS);
      mole_timer_d = MW'(MOLE_TICKS);
      correct_d    = 1'b0;
      wrong_d      = 1'b0;
      mole_d       = placed_pos;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          // Flags drop on tick; a flag raised by this cycle's hit survives.
          if (bus.tick) begin
            correct_d = 1'b0;
            wrong_d   = 1'b0;
          end

          if (hit_good) begin
            if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
              if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end
            correct_d    = 1'b1;
            mole_d       = placed_pos;
            mole_timer_d = MW'(MOLE_TICKS);
          end else if (hit_valid) begin
            wrong_d = 1'b1;
          end

          if (bus.tick) begin
            if (game_timer_q == GW'(1)) begin
              state_d   = ST_OVER;
              correct_d = 1'b0;
              wrong_d   = 1'b0;
            end else begin
              game_timer_d = game_timer_q - GW'(1);
              // A good hit already relocated and reloaded the mole this cycle.
              if (!hit_good) begin
                if (mole_timer_q == MW'(1)) begin
                  mole_d       = placed_pos;
                  mole_timer_d = MW'(MOLE_TICKS);
                end else begin
                  mole_timer_d = mole_timer_q - MW'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end

    game_over_d = (state_d == ST_OVER);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      mole_q       <= 3'd0;
      correct_q    <= 1'b0;
      wrong_q      <= 1'b0;
      game_over_q  <= 1'b0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      game_timer_q <= '0;
      mole_timer_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      mole_q       <= mole_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
      game_over_q  <= game_over_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      game_timer_q <= game_timer_d;
      mole_timer_q <= mole_timer_d;
    end
  end

  assign bus.mole_position = mole_q;
  assign bus.guess_correct = correct_q;
  assign bus.guess_wrong   = wrong_q;
  assign bus.game_over     = game_over_q;
  assign bus.digit_1       = tens_q;
  assign bus.digit_2       = ones_q;

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// Directed bench for whackamole_game_ctrl. dut_a runs a short 5-tick game for
// timer and game-over scenarios; dut_b runs a 255-tick game for score tests.
module tb_whackamole_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  whackamole_game_ctrl_if ia ();
  whackamole_game_ctrl_if ib ();

  whackamole_game_ctrl #(.GAME_TICKS(5), .MOLE_TICKS(2), .LFSR_SEED(8'hA5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  whackamole_game_ctrl #(.GAME_TICKS(255), .MOLE_TICKS(2), .LFSR_SEED(8'h5C)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  // One clock on dut_a with the given pulses; outputs sampled 1 time unit later.
  task automatic step_a(input logic t, input logic s, input logic [7:0] h);
    ia.tick = t; ia.start = s; ia.hit = h;
    @(posedge clk); #1;
    ia.tick = 1'b0; ia.start = 1'b0; ia.hit = 8'd0;
  endtask

  task automatic step_b(input logic t, input logic s, input logic [7:0] h);
    ib.tick = t; ib.start = s; ib.hit = h;
    @(posedge clk); #1;
    ib.tick = 1'b0; ib.start = 1'b0; ib.hit = 8'd0;
  endtask

  function automatic logic [14:0] outs_a();
    return {ia.mole_position, ia.guess_correct, ia.guess_wrong, ia.game_over,
            ia.digit_1, ia.digit_2};
  endfunction

  task automatic test_reset();
    ia.tick = 1'b1; ia.start = 1'b1; ia.hit = 8'hFF;
    ib.tick = 1'b1; ib.start = 1'b1; ib.hit = 8'h0F;
    rst = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0; ia.hit = 8'h01; ib.start = 1'b0; ib.hit = 8'hF0;
    n_tests++;
    if (outs_a() !== 15'd0) begin
      n_fail++; $display("FAIL reset_cycle1: outputs=%h required=0", outs_a());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ia.tick = 1'b0; ia.start = 1'b0; ia.hit = 8'd0;
    ib.tick = 1'b0; ib.start = 1'b0; ib.hit = 8'd0;
    n_tests++;
    if (outs_a() !== 15'd0) begin
      n_fail++; $display("FAIL reset_a: outputs=%h required=0", outs_a());
    end
    n_tests++;
    if ({ib.mole_position, ib.guess_correct, ib.guess_wrong, ib.game_over,
         ib.digit_1, ib.digit_2} !== 15'd0) begin
      n_fail++; $display("FAIL reset_b: outputs nonzero, required 0");
    end
    // IDLE ignores tick and hit.
    step_a(1'b1, 1'b0, 8'h01);
    step_a(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (outs_a() !== 15'd0) begin
      n_fail++; $display("FAIL idle_tick: outputs=%h required=0", outs_a());
    end
  endtask

  task automatic test_correct_hit();
    int p;
    int p2;
    step_a(1'b0, 1'b1, 8'd0);
    n_tests++;
    if ({ia.game_over, ia.guess_correct, ia.guess_wrong, ia.digit_1, ia.digit_2} !== 11'd0) begin
      n_fail++; $display("FAIL start_state: over/flags/score nonzero after start");
    end
    p = int'(ia.mole_position);
    step_a(1'b0, 1'b0, 8'(1 << p));
    n_tests++;
    if (ia.digit_1 !== 4'd0 || ia.digit_2 !== 4'd1) begin
      n_fail++; $display("FAIL hit_score: got %0d%0d required 01", ia.digit_1, ia.digit_2);
    end
    n_tests++;
    if (ia.guess_correct !== 1'b1 || ia.guess_wrong !== 1'b0) begin
      n_fail++; $display("FAIL hit_flags: correct=%b wrong=%b required 1/0", ia.guess_correct, ia.guess_wrong);
    end
    n_tests++;
    if (int'(ia.mole_position) == p) begin
      n_fail++; $display("FAIL hit_moves: mole=%0d required != %0d", ia.mole_position, p);
    end
    // Lockout: a second correct hit before the tick is ignored.
    p2 = int'(ia.mole_position);
    step_a(1'b0, 1'b0, 8'(1 << p2));
    n_tests++;
    if (ia.digit_2 !== 4'd1 || int'(ia.mole_position) != p2 || ia.guess_correct !== 1'b1) begin
      n_fail++; $display("FAIL lockout: score=%0d%0d mole=%0d required 01 mole %0d",
                         ia.digit_1, ia.digit_2, ia.mole_position, p2);
    end
    step_a(1'b1, 1'b0, 8'd0);
    n_tests++;
    if (ia.guess_correct !== 1'b0) begin
      n_fail++; $display("FAIL correct_clear: correct=%b required 0", ia.guess_correct);
    end
    // Restart mid-game clears the score.
    step_a(1'b0, 1'b1, 8'd0);
    n_tests++;
    if ({ia.digit_1, ia.digit_2, ia.game_over} !== 9'd0) begin
      n_fail++; $display("FAIL restart: score=%0d%0d over=%b required 00/0", ia.digit_1, ia.digit_2, ia.game_over);
    end
  endtask

  task automatic test_wrong_hit();
    logic [2:0] q;
    step_a(1'b0, 1'b1, 8'd0);
    q = ia.mole_position;
    step_a(1'b0, 1'b0, 8'b0000_0011);
    n_tests++;
    if (ia.guess_wrong !== 1'b1 || ia.guess_correct !== 1'b0) begin
      n_fail++; $display("FAIL wrong_flag: wrong=%b correct=%b required 1/0", ia.guess_wrong, ia.guess_correct);
    end
    n_tests++;
    if ({ia.digit_1, ia.digit_2} !== 8'h00 || ia.mole_position !== q) begin
      n_fail++; $display("FAIL wrong_nochange: score=%0d%0d mole=%0d required 00 mole %0d",
                         ia.digit_1, ia.digit_2, ia.mole_position, q);
    end
    step_a(1'b1, 1'b0, 8'd0);
    n_tests++;
    if (ia.guess_wrong !== 1'b0) begin
      n_fail++; $display("FAIL wrong_clear: wrong=%b required 0", ia.guess_wrong);
    end
  endtask

  task automatic test_timers();
    logic [2:0] m;
    step_a(1'b0, 1'b1, 8'd0);
    for (int t = 1; t <= 4; t++) begin
      m = ia.mole_position;
      step_a(1'b1, 1'b0, 8'd0);
      n_tests++;
      if ((t % 2 == 0) ? (ia.mole_position === m) : (ia.mole_position !== m)) begin
        n_fail++; $display("FAIL mole_timer: tick %0d mole=%0d previous=%0d moved_required=%0d",
                           t, ia.mole_position, m, (t % 2 == 0));
      end
      n_tests++;
      if (ia.game_over !== 1'b0) begin
        n_fail++; $display("FAIL early_over: tick %0d game_over=%b required 0", t, ia.game_over);
      end
    end
    m = ia.mole_position;
    step_a(1'b1, 1'b0, 8'd0);
    n_tests++;
    if (ia.game_over !== 1'b1 || ia.mole_position !== m) begin
      n_fail++; $display("FAIL game_end: over=%b mole=%0d required 1 mole %0d", ia.game_over, ia.mole_position, m);
    end
    // OVER ignores hit and tick.
    step_a(1'b1, 1'b0, 8'(1 << int'(m)));
    step_a(1'b1, 1'b0, 8'hFF);
    n_tests++;
    if ({ia.game_over, ia.guess_correct, ia.guess_wrong, ia.digit_1, ia.digit_2} !== 11'b100_0000_0000
        || ia.mole_position !== m) begin
      n_fail++; $display("FAIL over_frozen: over=%b c=%b w=%b score=%0d%0d mole=%0d required 1/0/0 00 mole %0d",
                         ia.game_over, ia.guess_correct, ia.guess_wrong, ia.digit_1, ia.digit_2,
                         ia.mole_position, m);
    end
    step_a(1'b0, 1'b1, 8'd0);
    n_tests++;
    if (ia.game_over !== 1'b0 || {ia.digit_1, ia.digit_2} !== 8'h00) begin
      n_fail++; $display("FAIL over_restart: over=%b score=%0d%0d required 0 00", ia.game_over, ia.digit_1, ia.digit_2);
    end
  endtask

  task automatic test_hit_final_tick();
    int p;
    step_a(1'b0, 1'b1, 8'd0);
    for (int t = 1; t <= 4; t++) step_a(1'b1, 1'b0, 8'd0);
    p = int'(ia.mole_position);
    step_a(1'b1, 1'b0, 8'(1 << p));
    n_tests++;
    if ({ia.digit_1, ia.digit_2} !== 8'h01 || ia.game_over !== 1'b1) begin
      n_fail++; $display("FAIL hit_final_tick: score=%0d%0d over=%b required 01/1",
                         ia.digit_1, ia.digit_2, ia.game_over);
    end
    n_tests++;
    if (ia.guess_correct !== 1'b0 || ia.guess_wrong !== 1'b0) begin
      n_fail++; $display("FAIL over_flags: correct=%b wrong=%b required 0/0", ia.guess_correct, ia.guess_wrong);
    end
  endtask

  task automatic test_score_saturation();
    int p;
    int exp;
    step_b(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 105; i++) begin
      p = int'(ib.mole_position);
      step_b(1'b0, 1'b0, 8'(1 << p));
      exp = (i + 1 > 99) ? 99 : i + 1;
      n_tests++;
      if (int'(ib.digit_1) != exp / 10 || int'(ib.digit_2) != exp % 10 || ib.guess_correct !== 1'b1) begin
        n_fail++; $display("FAIL score_%0d: got %0d%0d correct=%b required %0d%0d correct=1",
                           i + 1, ib.digit_1, ib.digit_2, ib.guess_correct, exp / 10, exp % 10);
      end
      step_b(1'b1, 1'b0, 8'd0);
    end
    n_tests++;
    if (ib.game_over !== 1'b0) begin
      n_fail++; $display("FAIL score_game_over: over=%b required 0", ib.game_over);
    end
  endtask

  initial begin
    ia.tick = 1'b0; ia.start = 1'b0; ia.hit = 8'd0;
    ib.tick = 1'b0; ib.start = 1'b0; ib.hit = 8'd0;
    #2;
    test_reset();
    test_correct_hit();
    test_wrong_hit();
    test_timers();
    test_hit_final_tick();
    test_score_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
